// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the rexta instruction fetch stage.
// Contents: NOP encoding, prefetch FIFO entry payload, fetch FSM states.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } fetch_state_t;

    // Value seen at the FIFO head straight out of reset
    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, instr: NOP_INSTR, fault: 1'b0};

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: prefetch buffer holding {pc, instr, fault} entries.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push/wdata write an entry (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   flush      empty the buffer; wins over push and pop
//   count      number of valid entries (0..DEPTH)
//   head       oldest entry; stale contents when count == 0
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = push && (r_count < CNT_W'(DEPTH));
    assign w_pop  = pop && (r_count != '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];

    // Storage is reset so the head shows a NOP at PC 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rexta instruction fetch stage.
// Issues sequential word fetches on the instruction memory port, buffers
// returned words with their PC in a prefetch FIFO and hands them to decode
// over a valid/ready handshake. Redirects from execute flush and restart.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect -> FAULT,
// presenting a persistent fault marker entry).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_cs, mem_addr                 fetch request / word address
//   mem_rdata, mem_ready             returned word / transfer complete
//   redirect_valid, redirect_pc      PC change request from execute
//   instr_valid, instr, instr_pc,    FIFO head towards decode
//   instr_fault, instr_ready
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_fifo_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;

    assign w_fifo_valid = (w_count != '0);
    assign w_push       = mem_cs && mem_ready;
    assign w_push_entry = '{pc: r_fetch_pc, instr: mem_rdata, fault: 1'b0};
    assign mem_addr     = r_fetch_pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_push_entry),
        .pop   (w_pop),
        .flush (w_flush),
        .count (w_count),
        .head  (w_head)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and issue logic; redirect overrides everything
    always_comb begin
        w_state_nxt = r_state;
        mem_cs      = 1'b0;
        w_flush     = redirect_valid;
        w_pop       = w_fifo_valid && instr_ready && !redirect_valid;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     mem_cs = (w_count < CNT_W'(DEPTH)) && !redirect_valid;
            default: w_state_nxt = r_state;
        endcase
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_EN
            w_state_nxt = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
            w_state_nxt = RUN;
`endif
        end
    end

    // Fetch address: redirect target (word-masked) or advance on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic [31:0] r_fault_pc;

    // Unmasked target, only meaningful while in FAULT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_fault_pc <= redirect_pc;
        end
    end

    // In FAULT the (flushed) buffer shows a single sticky fault marker
    always_comb begin
        instr_valid = w_fifo_valid;
        instr       = w_head.instr;
        instr_pc    = w_head.pc;
        instr_fault = w_head.fault;
        if (r_state == FAULT) begin
            instr_valid = 1'b1;
            instr       = NOP_INSTR;
            instr_pc    = r_fault_pc;
            instr_fault = 1'b1;
        end
    end
`else
    assign instr_valid = w_fifo_valid;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign instr_fault = 1'b0;

    // Low PC bits and the stored fault flag have no meaning in this build
    logic w_unused;
    assign w_unused = ^{redirect_pc[1:0], w_head.fault};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model with programmable wait
// states, directed phases, expected deliveries queued by the stimulus and
// popped/compared by an independent monitor on every decode handshake.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    logic [31:0] wait_addr = 32'hFFFF_FFFF;
    int unsigned wait_n    = 0;
    int unsigned wait_cnt  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_cs         (mem_cs),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .instr_ready    (instr_ready)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h1000_1137;
        return a ^ 32'hA5A5_0003;
    endfunction

    // ROM slave: wait_n wait states on every access to wait_addr
    assign mem_rdata = rom_word(mem_addr);
    assign mem_ready = !(mem_cs && (mem_addr == wait_addr) && (wait_cnt < wait_n));
    always @(posedge clk) wait_cnt <= (mem_cs && !mem_ready) ? wait_cnt + 1 : 0;

    // Monitor: every accepted head must match the next expected entry
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL delivery: got pc=%h instr=%h fault=%0d, expected nothing (cycle %0d)",
                         instr_pc, instr, instr_fault, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr_pc !== mon_e.pc || instr !== mon_e.instr || instr_fault !== mon_e.fault) begin
                    n_fail++;
                    $display("FAIL delivery: got pc=%h instr=%h fault=%0d, expected pc=%h instr=%h fault=%0d",
                             instr_pc, instr, instr_fault, mon_e.pc, mon_e.instr, mon_e.fault);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic fault);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = fault ? NOP_INSTR : rom_word(pc);
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    // Reset (possibly mid-transfer), check reset outputs, release into BOOT
    task automatic do_reset();
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        exp_q.delete();
        check("rst_mem_cs", 32'(mem_cs), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_fault", 32'(instr_fault), 32'h0);
        rst = 1'b0;
        cyc = 1;
        #1;
        check("boot_idle_cs", 32'(mem_cs), 32'h0);
    endtask

    // Run until all expected deliveries seen; exp_cyc pins the timing
    task automatic drain(input int exp_cyc, input string name);
        while (exp_q.size() != 0 && cyc < 400) step();
        instr_ready = 1'b0;
        check(name, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        exp_q.delete();
        #1;
        check("redirect_cs_low", 32'(mem_cs), 32'h0);
    endtask

    initial begin
        // Zero-wait ROM, decode always ready: one instruction per cycle
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_push(32'(i * 4), 1'b0);
        step();
        check("first_cs", 32'(mem_cs), 32'h1);
        check("first_addr", mem_addr, 32'h0);
        drain(8, "stream_timing");

        // Decode stalled: buffer fills to DEPTH and requests stop
        do_reset();
        repeat (10) step();
        check("full_valid", 32'(instr_valid), 32'h1);
        check("full_cs", 32'(mem_cs), 32'h0);
        check("full_head_pc", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4), 1'b0);
        instr_ready = 1'b1;
        step();
        check("resume_cs", 32'(mem_cs), 32'h1);
        check("resume_addr", mem_addr, 32'h8);
        drain(15, "backpressure_timing");

        // Two wait states on 0x4: address held, no extra bubbles
        wait_addr = 32'h4;
        wait_n    = 2;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4), 1'b0);
        step();
        check("ws_addr_c2", mem_addr, 32'h0);
        step();
        check("ws_addr_c3", mem_addr, 32'h4);
        check("ws_ready_c3", 32'(mem_ready), 32'h0);
        step();
        check("ws_addr_c4", mem_addr, 32'h4);
        step();
        check("ws_addr_c5", mem_addr, 32'h4);
        check("ws_ready_c5", 32'(mem_ready), 32'h1);
        drain(9, "waitstate_timing");
        wait_addr = 32'hFFFF_FFFF;

        // Redirect to 0x20 while the request to 0x10 is stalled
        wait_addr = 32'h10;
        wait_n    = 1000;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4), 1'b0);
        drain(7, "pre_redirect_timing");
        check("stall_addr", mem_addr, 32'h10);
        check("stall_cs", 32'(mem_cs), 32'h1);
        redirect_to(32'h20);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_addr", mem_addr, 32'h20);
        check("redir_cs", 32'(mem_cs), 32'h1);
        check("redir_empty", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 3; i++) exp_push(32'h20 + 32'(i * 4), 1'b0);
        instr_ready = 1'b1;
        drain(12, "post_redirect_timing");
        wait_addr = 32'hFFFF_FFFF;

        // Redirect coinciding with a pop: popped head is discarded
        do_reset();
        instr_ready = 1'b1;
        exp_push(32'h0, 1'b0);
        exp_push(32'h4, 1'b0);
        drain(5, "pre_flush_timing");
        instr_ready = 1'b1;
        check("flush_head_valid", 32'(instr_valid), 32'h1);
        redirect_to(32'h40);
        step();
        redirect_valid = 1'b0;
        #1;
        check("flush_empty", 32'(instr_valid), 32'h0);
        check("flush_addr", mem_addr, 32'h40);
        check("flush_cs", 32'(mem_cs), 32'h1);
        exp_push(32'h40, 1'b0);
        exp_push(32'h44, 1'b0);
        drain(9, "post_flush_timing");

        // Misaligned redirect to 0x22
        redirect_to(32'h22);
        base = cyc;
        step();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_EN
        check("fault_valid", 32'(instr_valid), 32'h1);
        check("fault_flag", 32'(instr_fault), 32'h1);
        check("fault_pc", instr_pc, 32'h22);
        check("fault_instr", instr, 32'h0000_0013);
        check("fault_cs", 32'(mem_cs), 32'h0);
        for (int i = 0; i < 3; i++) exp_push(32'h22, 1'b1);
        instr_ready = 1'b1;
        drain(base + 4, "fault_pops_timing");
        check("fault_persist_valid", 32'(instr_valid), 32'h1);
        check("fault_persist_flag", 32'(instr_fault), 32'h1);
        redirect_to(32'h40);
        base = cyc;
        step();
        redirect_valid = 1'b0;
        #1;
        check("unfault_addr", mem_addr, 32'h40);
        check("unfault_cs", 32'(mem_cs), 32'h1);
        check("unfault_empty", 32'(instr_valid), 32'h0);
        exp_push(32'h40, 1'b0);
        exp_push(32'h44, 1'b0);
        instr_ready = 1'b1;
        drain(base + 4, "unfault_timing");
`else
        check("misalign_addr", mem_addr, 32'h20);
        check("misalign_cs", 32'(mem_cs), 32'h1);
        check("misalign_fault", 32'(instr_fault), 32'h0);
        exp_push(32'h20, 1'b0);
        exp_push(32'h24, 1'b0);
        instr_ready = 1'b1;
        drain(base + 4, "misalign_timing");
`endif

        // Back-to-back redirects (last wins), then PC wraps past 0xFFFFFFFC
        redirect_to(32'h100);
        step();
        redirect_pc = 32'hFFFF_FFF8;
        base = cyc;
        step();
        redirect_valid = 1'b0;
        #1;
        check("b2b_addr", mem_addr, 32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFF8, 1'b0);
        exp_push(32'hFFFF_FFFC, 1'b0);
        exp_push(32'h0000_0000, 1'b0);
        exp_push(32'h0000_0004, 1'b0);
        instr_ready = 1'b1;
        drain(base + 6, "wrap_timing");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
